// File: rtl/ex_mem_latch_if.sv
// ex_mem_latch_if: EX-side inputs and MEM-side registered outputs of the EX/MEM pipeline register
interface ex_mem_latch_if;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic        ex_reg_write;
  logic        ex_mem_to_reg;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_wr_data;
  logic [4:0]  ex_rd_addr;
  logic        mem_valid;
  logic        mem_reg_write;
  logic        mem_mem_to_reg;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_wr_data;
  logic [4:0]  mem_rd_addr;
  logic [15:0] stall_cnt;
  modport master (
    output stall, flush, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_alu_result, ex_wr_data, ex_rd_addr,
    input  mem_valid, mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write,
           mem_alu_result, mem_wr_data, mem_rd_addr, stall_cnt
  );
  modport slave (
    input  stall, flush, ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
           ex_alu_result, ex_wr_data, ex_rd_addr,
    output mem_valid, mem_reg_write, mem_mem_to_reg, mem_mem_read, mem_mem_write,
           mem_alu_result, mem_wr_data, mem_rd_addr, stall_cnt
  );
endinterface

// File: rtl/ex_mem_latch.sv
// ex_mem_latch: EX/MEM pipeline register with miss-stall hold, flush bubbles and a saturating stall counter
module ex_mem_latch (
  input  logic          clk,
  input  logic          rst,
  ex_mem_latch_if.slave bus
);
  logic        valid, reg_write, mem_to_reg, mem_read, mem_write;
  logic [31:0] alu_result, wr_data;
  logic [4:0]  rd_addr;
  logic [15:0] stall_cnt;
  logic        ld, live;
  assign ld   = !bus.flush;
  assign live = ld && bus.ex_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      reg_write  <= 1'b0;
      mem_to_reg <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      alu_result <= '0;
      wr_data    <= '0;
      rd_addr    <= '0;
      stall_cnt  <= '0;
    end else if (bus.stall) begin
      if (~&stall_cnt) stall_cnt <= stall_cnt + 16'd1;
    end else begin
      valid      <= live;
      reg_write  <= live && bus.ex_reg_write && |bus.ex_rd_addr;
      mem_to_reg <= live && bus.ex_mem_to_reg;
      mem_read   <= live && bus.ex_mem_read;
      mem_write  <= live && bus.ex_mem_write && !bus.ex_mem_read;
      alu_result <= ld ? bus.ex_alu_result : '0;
      wr_data    <= ld ? bus.ex_wr_data : '0;
      rd_addr    <= ld ? bus.ex_rd_addr : '0;
    end
  end
  // a load and a store on one instruction is a decoder bug; the load wins in hardware
  always_ff @(posedge clk)
    if (!rst && bus.ex_valid)
      assert (!(bus.ex_mem_read && bus.ex_mem_write))
        else $warning("ex_mem_latch: error, MemRead and MemWrite both set; MemWrite dropped");
  assign bus.mem_valid      = valid;
  assign bus.mem_reg_write  = reg_write;
  assign bus.mem_mem_to_reg = mem_to_reg;
  assign bus.mem_mem_read   = mem_read;
  assign bus.mem_mem_write  = mem_write;
  assign bus.mem_alu_result = alu_result;
  assign bus.mem_wr_data    = wr_data;
  assign bus.mem_rd_addr    = rd_addr;
  assign bus.stall_cnt      = stall_cnt;
endmodule

// File: tb/tb_ex_mem_latch.sv
// tb_ex_mem_latch: directed and random checks of ex_mem_latch against a rule-level reference model
module tb_ex_mem_latch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  ex_mem_latch_if bus();
  ex_mem_latch dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct packed {
    logic        valid, rw, m2r, mr, mw;
    logic [31:0] alu, wd;
    logic [4:0]  rd;
  } out_t;
  out_t exp_o;
  int   exp_cnt;
  function automatic out_t observed();
    return '{bus.mem_valid, bus.mem_reg_write, bus.mem_mem_to_reg, bus.mem_mem_read,
             bus.mem_mem_write, bus.mem_alu_result, bus.mem_wr_data, bus.mem_rd_addr};
  endfunction
  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] expv);
    compared++;
    assert (obs === expv)
      else begin
        mismatched++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
  endtask
  task automatic step(input string tag);
    @(posedge clk);
    if (rst) begin
      exp_o   = '0;
      exp_cnt = 0;
    end else if (bus.stall) exp_cnt = exp_cnt == 65535 ? 65535 : exp_cnt + 1;
    else if (bus.flush) exp_o = '0;
    else begin
      exp_o.valid = bus.ex_valid;
      exp_o.rw    = bus.ex_valid & bus.ex_reg_write & (bus.ex_rd_addr != 5'd0);
      exp_o.m2r   = bus.ex_valid & bus.ex_mem_to_reg;
      exp_o.mr    = bus.ex_valid & bus.ex_mem_read;
      exp_o.mw    = bus.ex_valid & bus.ex_mem_write & ~bus.ex_mem_read;
      exp_o.alu   = bus.ex_alu_result;
      exp_o.wd    = bus.ex_wr_data;
      exp_o.rd    = bus.ex_rd_addr;
    end
    #1;
    check({tag, ".out"}, 80'(observed()), 80'(exp_o));
    check({tag, ".cnt"}, 80'(bus.stall_cnt), 80'(exp_cnt));
  endtask
  task automatic rand_in();
    bus.ex_valid      = 1'($urandom);
    bus.ex_reg_write  = 1'($urandom);
    bus.ex_mem_to_reg = 1'($urandom);
    bus.ex_mem_read   = 1'($urandom);
    bus.ex_mem_write  = 1'($urandom) & ~bus.ex_mem_read;
    bus.ex_alu_result = $urandom;
    bus.ex_wr_data    = $urandom;
    bus.ex_rd_addr    = 5'($urandom);
  endtask
  task automatic set_in(input logic v, rw, m2r, mr, mw, input logic [31:0] alu, wd, input logic [4:0] rd);
    bus.ex_valid      = v;
    bus.ex_reg_write  = rw;
    bus.ex_mem_to_reg = m2r;
    bus.ex_mem_read   = mr;
    bus.ex_mem_write  = mw;
    bus.ex_alu_result = alu;
    bus.ex_wr_data    = wd;
    bus.ex_rd_addr    = rd;
  endtask
  initial begin
    out_t held;
    exp_o   = '0;
    exp_cnt = 0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    rand_in();
    rst = 1'b1;
    step("reset1");
    check("reset1.zero", 80'(observed()), 80'(0));
    rand_in();
    bus.stall = 1'b1;
    step("reset2");
    rst = 1'b0;
    bus.stall = 1'b0;
    set_in(1, 1, 0, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 5'd8);
    step("normal");
    check("normal.valid_rw", 80'({bus.mem_valid, bus.mem_reg_write}), 80'(2'b11));
    check("normal.data", 80'({bus.mem_alu_result, bus.mem_wr_data, bus.mem_rd_addr}),
          80'({32'h0000_0010, 32'hDEAD_BEEF, 5'd8}));
    bus.ex_rd_addr = 5'd0;
    step("rd0");
    check("rd0.rw", 80'(bus.mem_reg_write), 80'(0));
    set_in(1, 0, 0, 0, 1, 32'h40, 32'h1234_5678, 5'd3);
    step("store");
    held = observed();
    bus.stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_in();
      bus.flush = 1'($urandom);
      step("stall");
      check("stall.hold", 80'(observed()), 80'(held));
    end
    check("stall.cnt5", 80'(bus.stall_cnt), 80'(16'd5));
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    set_in(1, 1, 1, 1, 0, 32'hCAFE_0000, 32'h0BAD_F00D, 5'd17);
    step("release");
    check("release.alu", 80'(bus.mem_alu_result), 80'(32'hCAFE_0000));
    set_in(1, 1, 1, 1, 0, 32'h1111_2222, 32'h3333_4444, 5'd9);
    bus.flush = 1'b1;
    step("flush");
    check("flush.zero", 80'(observed()), 80'(0));
    check("flush.cnt", 80'(bus.stall_cnt), 80'(16'd5));
    bus.flush = 1'b0;
    step("reload");
    held = observed();
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    step("stallflush");
    check("stallflush.hold", 80'(observed()), 80'(held));
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    set_in(0, 1, 1, 1, 1, 32'h5555_AAAA, 32'hAAAA_5555, 5'd31);
    step("invalid");
    check("invalid.ctl", 80'({bus.mem_valid, bus.mem_reg_write, bus.mem_mem_to_reg,
          bus.mem_mem_read, bus.mem_mem_write}), 80'(0));
    bus.ex_valid = 1'b1;
    step("conflict");
    check("conflict.rw", 80'({bus.mem_mem_read, bus.mem_mem_write}), 80'(2'b10));
    for (int i = 0; i < 400; i++) begin
      rand_in();
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 4) == 0);
      rst       = ($urandom_range(0, 40) == 0);
      step("random");
    end
    rst = 1'b1;
    step("presat");
    rst = 1'b0;
    bus.stall = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      @(posedge clk);
      exp_cnt = exp_cnt == 65535 ? 65535 : exp_cnt + 1;
    end
    #1;
    check("sat.cnt", 80'(bus.stall_cnt), 80'(16'hFFFF));
    check("sat.model", 80'(bus.stall_cnt), 80'(exp_cnt));
    step("sat.stay");
    rst = 1'b1;
    step("sat.rst");
    check("sat.rst0", 80'(bus.stall_cnt), 80'(0));
    rst = 1'b0;
    step("sat.restart");
    check("sat.restart1", 80'(bus.stall_cnt), 80'(16'd1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ex_mem_latch.md
# ex_mem_latch

EX/MEM pipeline register of the five-stage CPU with data cache. It captures the EX-stage ALU result, the forwarded store data (output of the EX-stage forwarding mux), the destination register and the MEM/WB control bits, and presents them to the MEM stage and data cache. It holds its contents while the data cache signals a miss stall, inserts bubbles on flush, and counts stall cycles for performance measurement.

## Interface
- No parameters. Widths are fixed: 32-bit data, 5-bit register index, 16-bit counter.
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- stall_i  in  1  data-cache miss stall; hold all state
- flush_i  in  1  replace the incoming instruction with a bubble
- valid_i  in  1  EX stage holds a real instruction
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control bits from ID/EX
- alu_result_i  in  32  ALU result, used as memory address or writeback value
- wr_data_i  in  32  forwarded rt value, used as store data
- rd_addr_i  in  5  destination register index
- valid_o  out  1  MEM stage holds a real instruction
- RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o  out  1 each  registered control bits
- alu_result_o  out  32  registered ALU result; drives the data-cache address
- wr_data_o  out  32  registered store data
- rd_addr_o  out  5  registered destination index; also feeds the forwarding unit
- stall_cnt_o  out  16  saturating count of stalled cycles

## Operation
- All outputs are registered. There is no combinational path from input to output.
- Per-edge priority, highest first:
  - rst_i: clear everything.
  - stall_i: hold everything except stall_cnt_o.
  - flush_i: load a bubble.
  - Otherwise: normal load.
- Normal load:
  - Capture alu_result_i, wr_data_i and rd_addr_i.
  - valid_o <= valid_i.
  - Each control output <= its input AND valid_i.
  - RegWrite_o is also forced to 0 when rd_addr_i == 0, so register $0 is never written.
- Bubble, i.e. load on flush_i=1 with stall_i=0:
  - valid_o, all control bits, alu_result_o, wr_data_o and rd_addr_o all load 0.
  - A cleared bubble keeps forwarding-unit comparisons and cache address deterministic.
- Stall and flush together: stall wins and flush_i is ignored that cycle. The upstream stage also stalls and re-presents its flush request on the following cycle.
- MemRead_o and MemWrite_o are never both 1. If both inputs are 1 with valid_i=1:
  - MemRead_o takes priority (MemWrite_o is forced to 0).
  - Simulation prints an error message.
- stall_cnt_o:
  - Increments by 1 on every edge with stall_i=1 and rst_i=0.
  - Saturates at 16'hFFFF; no wrap.
  - Cleared only by rst_i. Flush does not affect it.

## Timing
- Reset values: every output is 0, including stall_cnt_o.
- Latency is exactly 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- During a stall of k cycles, outputs stay constant for k edges. This keeps the cache address and store data stable for the whole miss. The instruction present at stall_i rise is the one visible after stall_i falls.
- stall_cnt_o advances on the same edge at which stall_i is sampled high.
- If rst_i is asserted mid-stall, all state clears on that edge regardless of stall_i. The counter restarts at 0 and counts again from the next stalled edge.
- No valid/ready handshake. Stall is the only backpressure, and it is assumed to be stage-global.

## Test plan
- Reset: assert rst_i for 2 cycles with random inputs -> all outputs 0 and stall_cnt_o=0 after the first edge.
- Normal flow:
  - Stimulus: valid_i=1, RegWrite_i=1, rd_addr_i=5'd8, alu_result_i=32'h0000_0010, wr_data_i=32'hDEAD_BEEF.
  - Required response: values appear one edge later with valid_o=1 and RegWrite_o=1.
  - Repeat with rd_addr_i=0 -> RegWrite_o=0.
- Stall hold:
  - Stimulus: load a store (MemWrite_i=1, alu_result_i=32'h40, wr_data_i=32'h1234_5678), then stall_i=1 for 5 cycles while inputs change.
  - Required response: outputs unchanged for 5 edges and stall_cnt_o=5. The instruction presented on the release edge loads next.
- Flush: flush_i=1 with valid_i=1 and MemRead_i=1 -> next edge all outputs 0 except stall_cnt_o. With stall_i=1 on the same cycle, the previous contents are held instead.
- Saturation: hold stall_i=1 for 65540 cycles -> stall_cnt_o reaches 16'hFFFF and stays there. Then rst_i=1 -> 0.
- Invalid and conflicting controls:
  - valid_i=0 with all control inputs 1 -> valid_o=0 and all control outputs 0.
  - valid_i=1 with MemRead_i=MemWrite_i=1 -> MemRead_o=1, MemWrite_o=0, and an error message is printed.
